// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Opcodes and receiver state encoding for the 8080-style
//                display write bus.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CASET_P  = 3'd1,
        ST_PASET_P  = 3'd2,
        ST_RAMWR_HI = 3'd3,
        ST_RAMWR_LO = 3'd4,
        ST_IGNORE   = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_sync
//  Description : Synchronises {wr,dcx,D} as one bundle and flags each wr rise.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       wr,
    input  logic       dcx,
    input  logic [7:0] D,
    output logic       byte_stb,
    output logic       byte_dcx,
    output logic [7:0] byte_d
);

    // Bit 9 = wr, bit 8 = dcx, bits 7:0 = D; all three travel together so the
    // byte is stable in the same stage where the wr edge is seen.
    logic [SYNC_STAGES-1:0][9:0] r_pipe;
    logic                        r_wr_prev;

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            r_pipe    <= '0;
            r_wr_prev <= 1'b0;
        end else begin
            r_pipe    <= {r_pipe[SYNC_STAGES-2:0], wr, dcx, D};
            r_wr_prev <= r_pipe[SYNC_STAGES-1][9];
        end
    end

    assign byte_stb = r_pipe[SYNC_STAGES-1][9] & ~r_wr_prev;
    assign byte_dcx = r_pipe[SYNC_STAGES-1][8];
    assign byte_d   = r_pipe[SYNC_STAGES-1][7:0];

endmodule
`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_receiver
//  Description : Decodes the display command stream, tracks the address
//                window and emits one strobe per RGB565 pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int H_RES       = 240,
    parameter int V_RES       = 320,
    parameter int COORD_W     = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic               hwclk,
    input  logic               reset,
    input  logic               wr,
    input  logic               dcx,
    input  logic [7:0]         D,
    output logic               cmd_valid,
    output logic [7:0]         cmd_byte,
    output logic               px_valid,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [15:0]        px_rgb,
    output logic               disp_on,
    output logic               err_flag
);

    localparam logic [COORD_W-1:0] C_H_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] C_V_MAX = COORD_W'(V_RES - 1);

    logic               w_stb;
    logic               w_dcx;
    logic [7:0]         w_d;
    logic [COORD_W-1:0] w_new_start;
    logic [COORD_W-1:0] w_new_end;
    logic [COORD_W-1:0] w_lim;
    logic               w_win_ok;

    rx_state_t          r_state;
    logic [1:0]         r_pc;
    logic [7:0]         r_p0;
    logic [7:0]         r_p1;
    logic [7:0]         r_p2;
    logic [7:0]         r_hi;
    logic [COORD_W-1:0] r_sc;
    logic [COORD_W-1:0] r_ec;
    logic [COORD_W-1:0] r_sr;
    logic [COORD_W-1:0] r_er;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    lcd_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .hwclk    (hwclk),
        .reset    (reset),
        .wr       (wr),
        .dcx      (dcx),
        .D        (D),
        .byte_stb (w_stb),
        .byte_dcx (w_dcx),
        .byte_d   (w_d)
    );

    // Evaluated while the last parameter byte is on the bus.
    assign w_new_start = COORD_W'({r_p0, r_p1});
    assign w_new_end   = COORD_W'({r_p2, w_d});
    assign w_lim       = (r_state == ST_CASET_P) ? C_H_MAX : C_V_MAX;
    assign w_win_ok    = (w_new_start <= w_new_end) && (w_new_end <= w_lim);

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_p0      <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_hi      <= '0;
            r_sc      <= '0;
            r_ec      <= C_H_MAX;
            r_sr      <= '0;
            r_er      <= C_V_MAX;
            r_x       <= '0;
            r_y       <= '0;
            cmd_valid <= 1'b0;
            cmd_byte  <= '0;
            px_valid  <= 1'b0;
            px_x      <= '0;
            px_y      <= '0;
            px_rgb    <= '0;
            disp_on   <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            px_valid  <= 1'b0;
            if (w_stb && !w_dcx) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= w_d;
                r_pc      <= '0;
                // Truncated parameter list or orphaned high byte
                if (r_state inside {ST_CASET_P, ST_PASET_P, ST_RAMWR_LO})
                    err_flag <= 1'b1;
                case (w_d)
                    CMD_CASET: r_state <= ST_CASET_P;
                    CMD_PASET: r_state <= ST_PASET_P;
                    CMD_RAMWR: begin
                        r_state <= ST_RAMWR_HI;
                        r_x     <= r_sc;
                        r_y     <= r_sr;
                    end
                    CMD_SWRESET: begin
                        r_state  <= ST_IDLE;
                        r_sc     <= '0;
                        r_ec     <= C_H_MAX;
                        r_sr     <= '0;
                        r_er     <= C_V_MAX;
                        disp_on  <= 1'b0;
                        err_flag <= 1'b0;
                    end
                    CMD_DISPON: begin
                        r_state <= ST_IDLE;
                        disp_on <= 1'b1;
                    end
                    CMD_DISPOFF: begin
                        r_state <= ST_IDLE;
                        disp_on <= 1'b0;
                    end
                    default: r_state <= ST_IGNORE;
                endcase
            end else if (w_stb) begin
                case (r_state)
                    ST_CASET_P, ST_PASET_P: begin
                        r_pc <= r_pc + 2'd1;
                        case (r_pc)
                            2'd0: r_p0 <= w_d;
                            2'd1: r_p1 <= w_d;
                            2'd2: r_p2 <= w_d;
                            default: begin
                                r_state <= ST_IGNORE;
                                if (!w_win_ok) begin
                                    err_flag <= 1'b1;
                                end else if (r_state == ST_CASET_P) begin
                                    r_sc <= w_new_start;
                                    r_ec <= w_new_end;
                                end else begin
                                    r_sr <= w_new_start;
                                    r_er <= w_new_end;
                                end
                            end
                        endcase
                    end
                    ST_RAMWR_HI: begin
                        r_hi    <= w_d;
                        r_state <= ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        px_valid <= 1'b1;
                        px_x     <= r_x;
                        px_y     <= r_y;
                        px_rgb   <= {r_hi, w_d};
                        r_state  <= ST_RAMWR_HI;
                        if (r_x < r_ec) begin
                            r_x <= r_x + 1'b1;
                        end else if (r_y < r_er) begin
                            r_x <= r_sc;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_sc;
                            r_y <= r_sr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_bus_receiver
//  Description : Directed bench with command/pixel scoreboards.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_bus_receiver;

    localparam int CW   = 9;
    localparam int SYNC = 2;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [15:0]   rgb;
    } px_t;

    logic          hwclk = 1'b0;
    logic          reset;
    logic          wr;
    logic          dcx;
    logic [7:0]    D;
    logic          cmd_valid;
    logic [7:0]    cmd_byte;
    logic          px_valid;
    logic [CW-1:0] px_x;
    logic [CW-1:0] px_y;
    logic [15:0]   px_rgb;
    logic          disp_on;
    logic          err_flag;

    logic [7:0] cmd_q[$];
    px_t        px_q[$];
    int         passed       = 0;
    int         total        = 0;
    int         cyc          = 0;
    int         cmd_count    = 0;
    int         last_cmd_cyc = -1;

    lcd_bus_receiver #(
        .H_RES       (240),
        .V_RES       (320),
        .COORD_W     (CW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .hwclk     (hwclk),
        .reset     (reset),
        .wr        (wr),
        .dcx       (dcx),
        .D         (D),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .px_valid  (px_valid),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_rgb    (px_rgb),
        .disp_on   (disp_on),
        .err_flag  (err_flag)
    );

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboards on every strobe.
    always @(negedge hwclk) begin
        if (reset === 1'b1) begin
            if (cmd_valid) begin
                cmd_count++;
                last_cmd_cyc = cyc;
                if (cmd_q.size() == 0) check("cmd_unexpected", 64'(cmd_byte), 64'hFFFF);
                else check("cmd_byte", 64'(cmd_byte), 64'(cmd_q.pop_front()));
            end
            if (px_valid) begin
                if (px_q.size() == 0) check("px_unexpected", 64'({px_x, px_y, px_rgb}), 64'hFFFF_FFFF_FFFF);
                else check("px_xy_rgb", 64'({px_x, px_y, px_rgb}), 64'(px_q.pop_front()));
            end
        end
    end

    task automatic send(input logic is_data, input logic [7:0] b, input int hold, output int rise);
        @(negedge hwclk);
        dcx = is_data;
        D   = b;
        wr  = 1'b1;
        rise = cyc + 1;
        repeat (hold) @(negedge hwclk);
        wr = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic cmd(input logic [7:0] b);
        int r;
        cmd_q.push_back(b);
        send(1'b0, b, 1, r);
    endtask

    task automatic dat(input logic [7:0] b);
        int r;
        send(1'b1, b, 1, r);
    endtask

    task automatic exp_px(input int x, input int y, input logic [15:0] rgb);
        px_q.push_back({CW'(x), CW'(y), rgb});
    endtask

    task automatic settle();
        repeat (SYNC + 6) @(negedge hwclk);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        check("px_q_drained", 64'(px_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({cmd_valid, cmd_byte, px_valid, px_x, px_y, px_rgb, disp_on, err_flag});
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int rise;
        reset = 1'b0;
        wr    = 1'b0;
        dcx   = 1'b0;
        D     = 8'h00;
        repeat (3) @(negedge hwclk);
        check("reset_outputs", all_outs(), 64'd0);
        reset = 1'b1;

        // Reset in the middle of a parameter list
        cmd(8'h29);
        cmd(8'h2A);
        dat(8'h00);
        dat(8'h0A);
        settle();
        check("disp_on_before_reset", 64'(disp_on), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 64'd0);
        repeat (2) @(negedge hwclk);
        reset = 1'b1;
        cmd(8'h2C);
        exp_px(0, 0, 16'h1234);
        dat(8'h12);
        dat(8'h34);
        settle();

        // 2x1 window at (10..11, 5)
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0B);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h05);
        cmd(8'h2C);
        exp_px(10, 5, 16'hF800);
        exp_px(11, 5, 16'h07E0);
        dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0);
        settle();
        check("err_after_window", 64'(err_flag), 64'd0);

        // Frame wrap inside the same window
        cmd(8'h2C);
        exp_px(10, 5, 16'hAAAA);
        exp_px(11, 5, 16'hBBBB);
        exp_px(10, 5, 16'hCCCC);
        dat(8'hAA); dat(8'hAA); dat(8'hBB); dat(8'hBB); dat(8'hCC); dat(8'hCC);
        settle();

        // Command interrupting a half pixel
        cmd(8'h2C);
        dat(8'hAB);
        cmd(8'h29);
        settle();
        check("err_after_interrupt", 64'(err_flag), 64'd1);
        check("disp_on_after_interrupt", 64'(disp_on), 64'd1);

        cmd(8'h01);
        settle();
        check("err_after_swreset", 64'(err_flag), 64'd0);
        check("disp_on_after_swreset", 64'(disp_on), 64'd0);

        // Bad window: start > end
        cmd(8'h2A); dat(8'h00); dat(8'h20); dat(8'h00); dat(8'h10);
        settle();
        check("err_bad_window", 64'(err_flag), 64'd1);
        cmd(8'h2C);
        exp_px(0, 0, 16'h55AA);
        dat(8'h55); dat(8'hAA);
        settle();
        cmd(8'h01);
        settle();
        check("err_cleared_swreset", 64'(err_flag), 64'd0);

        // Boundary: end column 239 and end page 319 are legal
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'hEF);
        cmd(8'h2B); dat(8'h01); dat(8'h3F); dat(8'h01); dat(8'h3F);
        cmd(8'h2C);
        exp_px(0, 319, 16'h0F0F);
        exp_px(1, 319, 16'hF0F0);
        dat(8'h0F); dat(8'h0F); dat(8'hF0); dat(8'hF0);
        settle();
        check("err_max_window", 64'(err_flag), 64'd0);
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'hF0);
        settle();
        check("err_end_eq_hres", 64'(err_flag), 64'd1);

        // Partial parameter list dropped by a new command
        cmd(8'h01);
        cmd(8'h2A); dat(8'h00); dat(8'h05);
        cmd(8'h2C);
        exp_px(0, 0, 16'h1122);
        dat(8'h11); dat(8'h22);
        settle();
        check("err_partial_params", 64'(err_flag), 64'd1);

        // wr held high for 5 cycles -> one strobe, SYNC cycles after the rise
        n0 = cmd_count;
        cmd_q.push_back(8'h2C);
        send(1'b0, 8'h2C, 5, rise);
        settle();
        check("held_wr_one_pulse", 64'(cmd_count - n0), 64'd1);
        check("held_wr_latency", 64'(last_cmd_cyc - rise), 64'(SYNC));
        check("cmd_byte_held", 64'(cmd_byte), 64'h2C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
